// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and constants for the switch debouncer
package switch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

  localparam int SYS_CLK_HZ              = 100_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit 2-flop synchronizer plus counter-qualified debounce FSM
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   din   in   raw asynchronous input
//   dout  out  debounced level
//   rise  out  one-cycle pulse when dout goes 0->1
//   fall  out  one-cycle pulse when dout goes 1->0
//   idle  out  high when no level change is being qualified
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic idle
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt counts samples of sync2_q that differ from db_q, including the one
  // that left IDLE; on the last qualifying sample the new level is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q != db_q) begin
          state_d = COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      COUNT: begin
        if (sync2_q == db_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          db_d    = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign idle = (state_q == IDLE);

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit synchronize and debounce of the board slide switches
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   sw      in   raw asynchronous switch inputs [WIDTH]
//   sw_db   out  debounced switch levels [WIDTH]
//   sw_rise out  one-cycle 0->1 pulses of sw_db [WIDTH]
//   sw_fall out  one-cycle 1->0 pulses of sw_db [WIDTH]
//   settled out  high when no bit has a change pending
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled
);

  logic [WIDTH-1:0] idle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw[i]),
      .dout (sw_db[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i]),
      .idle (idle[i])
    );
  end

  assign settled = &idle;

endmodule
